// File: rtl/arbitro_registro_pkg.sv
// Shared constants and types for the round-robin arbiter that owns a 2-bit shared register.
package arbitro_registro_pkg;

  localparam int NUM_REQ      = 4;
  localparam int DATA_W       = 2;
  localparam int MAX_HOLD_DEF = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  typedef logic [DATA_W-1:0] data_t;

  function automatic logic [NUM_REQ-1:0] owner_onehot(input logic [1:0] idx);
    return {{(NUM_REQ-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/arbitro_registro_if.sv
// Request/grant and shared-register bus between the requesters and the arbiter.
interface arbitro_registro_if;
  import arbitro_registro_pkg::*;

  logic [NUM_REQ-1:0] REQ;
  data_t              DATAIN0;
  data_t              DATAIN1;
  data_t              DATAIN2;
  data_t              DATAIN3;
  logic [NUM_REQ-1:0] GNT;
  data_t              DATAOUT;
  logic [1:0]         OWNER;
  logic               BUSY;
  logic               VALID;
  logic               TIMEOUT;

  modport master (
    output REQ, DATAIN0, DATAIN1, DATAIN2, DATAIN3,
    input  GNT, DATAOUT, OWNER, BUSY, VALID, TIMEOUT
  );

  modport slave (
    input  REQ, DATAIN0, DATAIN1, DATAIN2, DATAIN3,
    output GNT, DATAOUT, OWNER, BUSY, VALID, TIMEOUT
  );

endinterface

// File: rtl/reg_compartido_2b.sv
// Shared 2-bit register written only by the current grant owner.
module reg_compartido_2b
  import arbitro_registro_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  i_load,
  input  data_t i_d,
  output data_t o_q
);

  data_t r_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       r_q <= '0;
    else if (i_load) r_q <= i_d;
  end

  assign o_q = r_q;

endmodule

// File: rtl/arbitro_registro.sv
// Round-robin arbiter: grants one requester, loads its data into the shared
// register, and holds the grant until release or a MAX_HOLD timeout.
module arbitro_registro
  import arbitro_registro_pkg::*;
#(
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input logic               clk,
  input logic               reset,
  arbitro_registro_if.slave bus
);

  localparam logic [2:0] HOLD_LAST = 3'(MAX_HOLD - 1);

  logic [1:0] r_state;
  logic [1:0] r_owner;
  logic [2:0] r_cnt;
  logic       r_timeout;

  logic [1:0] w_win;
  data_t      w_din;
  data_t      w_dout;
  logic       w_load;
  logic       w_busy;

  // Scan from the highest offset down so the requester right after OWNER wins.
  always_comb begin
    w_win = r_owner;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (bus.REQ[r_owner + 2'(k)]) w_win = r_owner + 2'(k);
    end
  end

  always_comb begin
    case (r_owner)
      2'd0:    w_din = bus.DATAIN0;
      2'd1:    w_din = bus.DATAIN1;
      2'd2:    w_din = bus.DATAIN2;
      default: w_din = bus.DATAIN3;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_owner   <= 2'b11;
      r_cnt     <= 3'd0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (|bus.REQ) begin
            r_owner <= w_win;
            r_state <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          r_state <= ST_HOLD;
          r_cnt   <= 3'd0;
        end
        ST_HOLD: begin
          // A release on the limit cycle wins over the timeout.
          if (!bus.REQ[r_owner]) begin
            r_state <= ST_IDLE;
          end else if (r_cnt == HOLD_LAST) begin
            r_state   <= ST_IDLE;
            r_timeout <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 3'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign w_load = (r_state == ST_GRANT);
  assign w_busy = (r_state != ST_IDLE);

  reg_compartido_2b u_reg (
    .clk    (clk),
    .reset  (reset),
    .i_load (w_load),
    .i_d    (w_din),
    .o_q    (w_dout)
  );

  assign bus.GNT     = w_busy ? owner_onehot(r_owner) : '0;
  assign bus.DATAOUT = w_dout;
  assign bus.OWNER   = r_owner;
  assign bus.BUSY    = w_busy;
  assign bus.VALID   = (r_state == ST_HOLD) && (r_cnt == 3'd0);
  assign bus.TIMEOUT = r_timeout;

endmodule
